// File: rtl/music_flash_reader.sv
// rtl/music_flash_reader.sv - Avalon-MM flash read master streaming 16-bit audio samples
//
// Purpose: reads 32-bit words from sequential flash word addresses (one read
// outstanding at most), splits each word into two signed samples (low half
// first) and hands them to an audio sink over a valid/ready handshake.
// The current word address is shown on six active-low 7-segment displays.
//
// Ports:
//   clk, reset_reset_n          clock; asynchronous reset, asserted when high
//   flash_mem_*                 Avalon-MM master to the flash controller
//   sample_out/valid/ready      sample stream to the audio codec
//   hex0..hex5                  word address, hex0 = least significant nibble
//   ledr                        [0] read, [1] waiting for data, [2] sample valid,
//                               [3] one-cycle pulse on address wrap
//
// Build option: define MUSIC_ATTEN_EN to attenuate samples by 12 dB
// (arithmetic shift right by 2); handshake timing is unchanged.

module music_flash_reader #(
    parameter int ADDR_W    = 23,
    parameter int NUM_WORDS = 1048576
) (
    input  logic              clk,
    input  logic              reset_reset_n,
    output logic              flash_mem_read,
    output logic [ADDR_W-1:0] flash_mem_address,
    input  logic              flash_mem_waitrequest,
    input  logic [31:0]       flash_mem_readdata,
    input  logic              flash_mem_readdatavalid,
    output logic              flash_mem_write,
    output logic [6:0]        flash_mem_burstcount,
    output logic [3:0]        flash_mem_byteenable,
    output logic [31:0]       flash_mem_writedata,
    output logic [15:0]       sample_out,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic [6:0]        hex0,
    output logic [6:0]        hex1,
    output logic [6:0]        hex2,
    output logic [6:0]        hex3,
    output logic [6:0]        hex4,
    output logic [6:0]        hex5,
    output logic [9:0]        ledr
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_LO, S_HI} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              wrap_d;
    logic [31:0]       word_q;
    logic              read_q;
    logic              valid_q;
    logic [15:0]       sample_q;
    logic              wrap_q;

    function automatic logic [15:0] shape(input logic [15:0] h);
`ifdef MUSIC_ATTEN_EN
        shape = 16'($signed(h) >>> 2);
`else
        shape = h;
`endif
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    // Wrap explicitly at NUM_WORDS-1 so a partial address range loops cleanly.
    assign wrap_d = (addr_q == LAST_ADDR);
    assign addr_d = wrap_d ? '0 : addr_q + ADDR_W'(1);

    always_ff @(posedge clk or posedge reset_reset_n) begin
        if (reset_reset_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            word_q   <= '0;
            read_q   <= 1'b0;
            valid_q  <= 1'b0;
            sample_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    read_q  <= 1'b1;
                    state_q <= S_REQ;
                end
                S_REQ: begin
                    if (!flash_mem_waitrequest) begin
                        read_q  <= 1'b0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flash_mem_readdatavalid) begin
                        word_q   <= flash_mem_readdata;
                        sample_q <= shape(flash_mem_readdata[15:0]);
                        valid_q  <= 1'b1;
                        state_q  <= S_LO;
                    end
                end
                S_LO: begin
                    if (sample_ready) begin
                        sample_q <= shape(word_q[31:16]);
                        state_q  <= S_HI;
                    end
                end
                S_HI: begin
                    if (sample_ready) begin
                        valid_q <= 1'b0;
                        addr_q  <= addr_d;
                        wrap_q  <= wrap_d;
                        read_q  <= 1'b1;
                        state_q <= S_REQ;
                    end
                end
                default: begin
                    read_q  <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    logic [23:0] addr_ext;
    assign addr_ext = 24'(addr_q);

    assign flash_mem_read       = read_q;
    assign flash_mem_address    = addr_q;
    assign flash_mem_write      = 1'b0;
    assign flash_mem_burstcount = 7'd1;
    assign flash_mem_byteenable = 4'hF;
    assign flash_mem_writedata  = 32'd0;
    assign sample_out           = sample_q;
    assign sample_valid         = valid_q;

    assign hex0 = seg7(addr_ext[3:0]);
    assign hex1 = seg7(addr_ext[7:4]);
    assign hex2 = seg7(addr_ext[11:8]);
    assign hex3 = seg7(addr_ext[15:12]);
    assign hex4 = seg7(addr_ext[19:16]);
    assign hex5 = seg7(addr_ext[23:20]);

    assign ledr = {6'd0, wrap_q, valid_q, (state_q == S_WAIT), read_q};

endmodule

// File: tb/tb_music_flash_reader.sv
// tb/tb_music_flash_reader.sv - randomized self-checking bench for music_flash_reader
module tb_music_flash_reader;

    localparam int ADDR_W = 23;
    localparam int NW     = 4;

    logic              clk = 1'b0;
    logic              reset_reset_n;
    logic              flash_mem_read;
    logic [ADDR_W-1:0] flash_mem_address;
    logic              flash_mem_waitrequest;
    logic [31:0]       flash_mem_readdata;
    logic              flash_mem_readdatavalid;
    logic              flash_mem_write;
    logic [6:0]        flash_mem_burstcount;
    logic [3:0]        flash_mem_byteenable;
    logic [31:0]       flash_mem_writedata;
    logic [15:0]       sample_out;
    logic              sample_valid;
    logic              sample_ready;
    logic [6:0]        hex0, hex1, hex2, hex3, hex4, hex5;
    logic [9:0]        ledr;

    music_flash_reader #(.ADDR_W(ADDR_W), .NUM_WORDS(NW)) dut (
        .clk(clk), .reset_reset_n(reset_reset_n),
        .flash_mem_read(flash_mem_read), .flash_mem_address(flash_mem_address),
        .flash_mem_waitrequest(flash_mem_waitrequest),
        .flash_mem_readdata(flash_mem_readdata),
        .flash_mem_readdatavalid(flash_mem_readdatavalid),
        .flash_mem_write(flash_mem_write), .flash_mem_burstcount(flash_mem_burstcount),
        .flash_mem_byteenable(flash_mem_byteenable), .flash_mem_writedata(flash_mem_writedata),
        .sample_out(sample_out), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
        .ledr(ledr)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          exp_addr = 0;
    int          wrap_count = 0;
    logic [31:0] mem [NW];
    logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: sample value is the half-word, or floor(value/4) when attenuated.
    function automatic logic [15:0] exp_sample(input logic [15:0] h);
        int v;
        v = int'($signed(h));
`ifdef MUSIC_ATTEN_EN
        if (v < 0) v = (v - 3) / 4;
        else       v = v / 4;
`endif
        return v[15:0];
    endfunction

    task automatic check_hex(input int a);
        check("hex0", 32'(hex0), 32'(seg_tab[a % 16]));
        check("hex1_5", {4'd0, hex1, hex2, hex3, hex4}, {4'd0, 7'h40, 7'h40, 7'h40, 7'h40});
        check("hex5", 32'(hex5), 32'h40);
    endtask

    // Ends one cycle after acceptance, with the DUT waiting for data.
    task automatic do_request(input int stall);
        int t = 0;
        while (flash_mem_read !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("req_seen", 32'(flash_mem_read), 32'd1);
        check("req_addr", 32'(flash_mem_address), 32'(exp_addr));
        check_hex(exp_addr);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_read", 32'(flash_mem_read), 32'd1);
            check("stall_addr", 32'(flash_mem_address), 32'(exp_addr));
        end
        flash_mem_waitrequest = 1'b0;
        @(negedge clk);
        flash_mem_waitrequest = 1'b1;
        check("read_drop", 32'(flash_mem_read), 32'd0);
        check("wait_led", 32'(ledr), 32'b0000000010);
    endtask

    task automatic do_data(input int dly);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            check("wait_idle", {30'd0, sample_valid, flash_mem_read}, 32'd0);
        end
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata = mem[exp_addr];
        @(negedge clk);
        flash_mem_readdatavalid = 1'b0;
        flash_mem_readdata = $urandom;
        check("lo_valid", 32'(sample_valid), 32'd1);
        check("lo_sample", 32'(sample_out), 32'(exp_sample(mem[exp_addr][15:0])));
    endtask

    task automatic do_samples(input int hlo, input int hhi);
        int nxt;
        logic [31:0] w;
        w = mem[exp_addr];
        for (int i = 0; i < hlo; i++) begin
            @(negedge clk);
            check("lo_hold", {sample_valid, flash_mem_read, sample_out}, {1'b1, 1'b0, exp_sample(w[15:0])});
        end
        sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
        check("hi_sample", {sample_valid, sample_out}, {1'b1, exp_sample(w[31:16])});
        for (int i = 0; i < hhi; i++) begin
            @(negedge clk);
            check("hi_hold", {sample_valid, flash_mem_read, sample_out}, {1'b1, 1'b0, exp_sample(w[31:16])});
        end
        sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
        nxt = (exp_addr + 1) % NW;
        check("next_req", {sample_valid, flash_mem_read}, 32'b01);
        check("next_addr", 32'(flash_mem_address), 32'(nxt));
        check("wrap_led", 32'(ledr[3]), 32'(exp_addr == NW - 1));
        if (ledr[3]) wrap_count++;
        exp_addr = nxt;
    endtask

    task automatic serve(input int stall, input int dly, input int hlo, input int hhi);
        do_request(stall);
        do_data(dly);
        do_samples(hlo, hhi);
    endtask

    initial begin
        reset_reset_n = 1'b1;
        flash_mem_waitrequest = 1'b1;
        flash_mem_readdatavalid = 1'b0;
        flash_mem_readdata = 32'd0;
        sample_ready = 1'b0;
        mem[0] = 32'h1234ABCD;
        mem[1] = 32'h8000_0040;
        mem[2] = $urandom;
        mem[3] = $urandom;

        repeat (3) @(negedge clk);
        check("rst_read_valid", {30'd0, flash_mem_read, sample_valid}, 32'd0);
        check("rst_sample", 32'(sample_out), 32'd0);
        check("rst_addr", 32'(flash_mem_address), 32'd0);
        check("rst_ledr", 32'(ledr), 32'd0);
        check_hex(0);
        check("consts", {flash_mem_write, flash_mem_burstcount, flash_mem_byteenable},
              {1'b0, 7'd1, 4'hF});
        check("wdata", flash_mem_writedata, 32'd0);

        reset_reset_n = 1'b0;
        @(negedge clk);
        serve(3, 0, 0, 0);
        serve(0, 1, 5, 0);
        for (int i = 0; i < 3; i++)
            serve($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2));
        check("wrap_count", 32'(wrap_count), 32'd1);

        // Reset while waiting for data; stale readdatavalid must not produce samples.
        do_request($urandom_range(0, 2));
        reset_reset_n = 1'b1;
        @(negedge clk);
        check("mid_rst", {flash_mem_read, sample_valid, flash_mem_address}, 32'd0);
        @(negedge clk);
        reset_reset_n = 1'b0;
        exp_addr = 0;
        repeat (2) @(negedge clk);
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata = 32'hDEADBEEF;
        @(negedge clk);
        flash_mem_readdatavalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stale_valid", 32'(sample_valid), 32'd0);
            check("post_rst_req", {flash_mem_read, flash_mem_address}, {1'b1, 23'd0});
            @(negedge clk);
        end

        for (int i = 0; i < 6; i++) begin
            mem[(exp_addr + 2) % NW] = $urandom;
            serve($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
